// File: rtl/pic_wdt_sleep_ctrl.sv
// Watchdog timer, prescaler and SLEEP/WAKE sequencer for the PIC16C5x core.
// Optional wake-pin exit from SLEEP is enabled by defining PIC_WAKE_PIN_EN.
module pic_wdt_sleep_ctrl #(
    parameter int WDT_BITS    = 8,
    parameter int WAKE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wdt_tick,
    input  logic       wdt_en,
    input  logic       ex_clrwdt,
    input  logic       ex_sleep,
    input  logic       opt_psa,
    input  logic [2:0] opt_ps,
    input  logic       wake_req,
    output logic       core_hold,
    output logic       wdt_rst_req,
    output logic       to_n,
    output logic       pd_n,
    output logic       sleeping
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    state_t              state, stateNext;
    logic [6:0]          prescaler, prescalerNext;
    logic [WDT_BITS-1:0] counter, counterNext;
    logic [7:0]          wakeCnt, wakeCntNext;
    logic                toN, toNNext;
    logic                pdN, pdNNext;
    logic                rstReqQ, rstReqNext;

    logic [6:0]          psMask;
    logic                cntPulse;
    logic                timeout;
    logic                wakePin;

`ifdef PIC_WAKE_PIN_EN
    assign wakePin = wake_req;
`else
    logic unusedWakeReq;
    assign unusedWakeReq = wake_req;
    assign wakePin       = 1'b0;
`endif

    // Low opt_ps bits of the prescaler must all be ones for a tick to pass.
    assign psMask   = 7'((8'd1 << opt_ps) - 8'd1);
    assign cntPulse = wdt_en & wdt_tick & (~opt_psa | ((prescaler & psMask) == psMask));
    assign timeout  = cntPulse & (counter == {WDT_BITS{1'b1}});

    always_comb begin
        stateNext     = state;
        prescalerNext = prescaler;
        counterNext   = counter;
        wakeCntNext   = wakeCnt;
        toNNext       = toN;
        pdNNext       = pdN;
        rstReqNext    = 1'b0;

        if (!wdt_en) begin
            prescalerNext = '0;
            counterNext   = '0;
        end else begin
            if (!opt_psa) begin
                prescalerNext = '0;
            end else if (wdt_tick) begin
                prescalerNext = prescaler + 7'd1;
            end
            if (cntPulse) begin
                counterNext = counter + 1'b1;
            end
        end

        unique case (state)
            ST_RUN: begin
                if (ex_sleep) begin
                    prescalerNext = '0;
                    counterNext   = '0;
                    toNNext       = 1'b1;
                    pdNNext       = 1'b0;
                    stateNext     = ST_SLEEP;
                end else if (ex_clrwdt) begin
                    prescalerNext = '0;
                    counterNext   = '0;
                    toNNext       = 1'b1;
                    pdNNext       = 1'b1;
                end else if (timeout) begin
                    toNNext    = 1'b0;
                    pdNNext    = 1'b1;
                    rstReqNext = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (ex_clrwdt) begin
                    prescalerNext = '0;
                    counterNext   = '0;
                    toNNext       = 1'b1;
                    pdNNext       = 1'b1;
                end
                // A timeout beats a simultaneous wake request so TO records it.
                if (timeout && !ex_clrwdt) begin
                    toNNext     = 1'b0;
                    stateNext   = ST_WAKE;
                    wakeCntNext = 8'(WAKE_CYCLES - 1);
                end else if (wakePin) begin
                    stateNext   = ST_WAKE;
                    wakeCntNext = 8'(WAKE_CYCLES - 1);
                end
            end
            ST_WAKE: begin
                if (ex_clrwdt) begin
                    prescalerNext = '0;
                    counterNext   = '0;
                    toNNext       = 1'b1;
                    pdNNext       = 1'b1;
                end
                if (wakeCnt == 8'd0) begin
                    stateNext = ST_RUN;
                end else begin
                    wakeCntNext = wakeCnt - 8'd1;
                end
            end
            default: begin
                stateNext = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            prescaler <= '0;
            counter   <= '0;
            wakeCnt   <= '0;
            toN       <= 1'b1;
            pdN       <= 1'b1;
            rstReqQ   <= 1'b0;
        end else begin
            state     <= stateNext;
            prescaler <= prescalerNext;
            counter   <= counterNext;
            wakeCnt   <= wakeCntNext;
            toN       <= toNNext;
            pdN       <= pdNNext;
            rstReqQ   <= rstReqNext;
        end
    end

    // The wake pulse is decoded from flops only: last WAKE cycle, hold still high.
    assign wdt_rst_req = rstReqQ | ((state == ST_WAKE) && (wakeCnt == 8'd0));
    assign core_hold   = (state != ST_RUN);
    assign sleeping    = (state != ST_RUN);
    assign to_n        = toN;
    assign pd_n        = pdN;

endmodule

// File: tb/tb_pic_wdt_sleep_ctrl.sv
// Bench for pic_wdt_sleep_ctrl with WDT_BITS=4, WAKE_CYCLES=3; expected output
// vectors {core_hold, wdt_rst_req, to_n, pd_n, sleeping} are queued per step.
module tb_pic_wdt_sleep_ctrl;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wdt_tick;
    logic       wdt_en;
    logic       ex_clrwdt;
    logic       ex_sleep;
    logic       opt_psa;
    logic [2:0] opt_ps;
    logic       wake_req;
    logic       core_hold;
    logic       wdt_rst_req;
    logic       to_n;
    logic       pd_n;
    logic       sleeping;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    pic_wdt_sleep_ctrl #(
        .WDT_BITS   (4),
        .WAKE_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wdt_tick   (wdt_tick),
        .wdt_en     (wdt_en),
        .ex_clrwdt  (ex_clrwdt),
        .ex_sleep   (ex_sleep),
        .opt_psa    (opt_psa),
        .opt_ps     (opt_ps),
        .wake_req   (wake_req),
        .core_hold  (core_hold),
        .wdt_rst_req(wdt_rst_req),
        .to_n       (to_n),
        .pd_n       (pd_n),
        .sleeping   (sleeping)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got hold/req/to/pd/slp=%b, expected %b", tag, obs, exp);
        end
    endtask

    // One clk cycle of stimulus: inputs change at a negedge, outputs are read
    // at the following negedge, after the active edge has been taken.
    task automatic step(input logic tick, input logic clr, input logic slp,
                        input logic wreq, input logic rst);
        wdt_tick  = tick;
        ex_clrwdt = clr;
        ex_sleep  = slp;
        wake_req  = wreq;
        rst_n     = ~rst;
        @(negedge clk);
        wdt_tick  = 1'b0;
        ex_clrwdt = 1'b0;
        ex_sleep  = 1'b0;
        wake_req  = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic step_chk(input logic tick, input logic clr, input logic slp,
                            input logic wreq, input logic rst,
                            input string tag, input logic [W-1:0] exp);
        logic [W-1:0] e;
        string        t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step(tick, clr, slp, wreq, rst);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {core_hold, wdt_rst_req, to_n, pd_n, sleeping}, e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wdt_tick  = 1'b0;
        wdt_en    = 1'b1;
        ex_clrwdt = 1'b0;
        ex_sleep  = 1'b0;
        opt_psa   = 1'b0;
        opt_ps    = 3'd0;
        wake_req  = 1'b0;
        @(negedge clk);
        step_chk(0, 0, 0, 0, 1, "reset", 5'b00110);

        // Direct ticks: 15 quiet, the 16th times out.
        ticks(14);
        step_chk(1, 0, 0, 0, 0, "tick15_quiet", 5'b00110);
        step_chk(1, 0, 0, 0, 0, "tick16_timeout", 5'b01010);
        step_chk(0, 0, 0, 0, 0, "pulse_one_cycle", 5'b00010);
        step_chk(0, 1, 0, 0, 0, "clrwdt_sets_to", 5'b00110);

        // Prescaler 1:8, timeout on tick 128.
        opt_psa = 1'b1;
        opt_ps  = 3'd3;
        ticks(126);
        step_chk(1, 0, 0, 0, 0, "ps3_tick127", 5'b00110);
        step_chk(1, 0, 0, 0, 0, "ps3_tick128", 5'b01010);
        step(0, 1, 0, 0, 0);
        opt_ps = 3'd0;
        ticks(15);
        step_chk(1, 0, 0, 0, 0, "ps0_tick16", 5'b01010);
        step(0, 1, 0, 0, 0);

        // Clear coinciding with the would-be timeout.
        opt_psa = 1'b0;
        ticks(15);
        step_chk(1, 1, 0, 0, 0, "clr_beats_timeout", 5'b00110);
        ticks(14);
        step_chk(1, 0, 0, 0, 0, "after_clr_tick15", 5'b00110);
        step_chk(1, 0, 0, 0, 0, "after_clr_tick16", 5'b01010);
        step(0, 1, 0, 0, 0);

        // SLEEP, timeout, three WAKE cycles, reset request.
        step_chk(0, 0, 1, 0, 0, "sleep_entry", 5'b10101);
        step_chk(0, 0, 1, 0, 0, "sleep_ignores_sleep", 5'b10101);
        ticks(14);
        step_chk(1, 0, 0, 0, 0, "sleep_tick15", 5'b10101);
        step_chk(1, 0, 0, 0, 0, "sleep_timeout_wake1", 5'b10001);
        step_chk(0, 0, 0, 0, 0, "wake2", 5'b10001);
        step_chk(0, 0, 0, 0, 0, "wake3_pulse", 5'b11001);
        step_chk(0, 0, 0, 0, 0, "wake_done_run", 5'b00000);
        step_chk(0, 0, 0, 0, 0, "pd_stays_low", 5'b00000);
        step(0, 1, 0, 0, 0);

        // Wake request after five ticks.
        step(0, 0, 1, 0, 0);
        ticks(5);
`ifdef PIC_WAKE_PIN_EN
        step_chk(0, 0, 0, 1, 0, "wakepin_wake1", 5'b10101);
        step_chk(0, 0, 0, 0, 0, "wakepin_wake2", 5'b10101);
        step_chk(0, 0, 0, 0, 0, "wakepin_pulse", 5'b11101);
        step_chk(0, 0, 0, 0, 0, "wakepin_run", 5'b00100);
`else
        step_chk(0, 0, 0, 1, 0, "wakepin_ignored", 5'b10101);
        ticks(9);
        step_chk(1, 0, 0, 0, 0, "nopin_tick15", 5'b10101);
        step_chk(1, 0, 0, 0, 0, "nopin_tick16", 5'b10001);
        step_chk(0, 0, 0, 0, 0, "nopin_wake2", 5'b10001);
        step_chk(0, 0, 0, 0, 0, "nopin_pulse", 5'b11001);
        step_chk(0, 0, 0, 0, 0, "nopin_run", 5'b00000);
`endif
        step(0, 1, 0, 0, 0);

        // Reset during WAKE cycle 2 leaves no pulse behind.
        step(0, 0, 1, 0, 0);
        ticks(15);
        step_chk(1, 0, 0, 0, 0, "rst_wake1", 5'b10001);
        step_chk(0, 0, 0, 0, 1, "rst_in_wake", 5'b00110);
        step_chk(0, 0, 0, 0, 0, "rst_no_pulse", 5'b00110);
        step_chk(0, 0, 0, 0, 0, "rst_no_pulse2", 5'b00110);

        // Watchdog disabled: never times out, SLEEP only left by reset here.
        wdt_en = 1'b0;
        ticks(39);
        step_chk(1, 0, 0, 0, 0, "dis_no_timeout", 5'b00110);
        step_chk(0, 0, 1, 0, 0, "dis_sleep", 5'b10101);
        ticks(39);
        step_chk(1, 0, 0, 0, 0, "dis_stays_asleep", 5'b10101);
        step_chk(0, 1, 0, 0, 0, "dis_clr_in_sleep", 5'b10111);
        step_chk(0, 0, 0, 0, 1, "dis_reset_exit", 5'b00110);
        wdt_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
